// File: rtl/delay_ctrl_smoother.sv
// delay_ctrl_smoother: click-free control values for the audio delay stage.
// Optional length debounce: define DELAY_CTRL_DEBOUNCE_EN.
module delay_ctrl_smoother #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_BIT   = 16,
    parameter int STEP       = 64,
    parameter int GAIN_MAX   = 16384,
    parameter int FB_MAX     = 15565,
    parameter int DELAY_RST  = 1000,
    parameter int DEBOUNCE   = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_audio_valid,
    input  logic [ADDR_WIDTH-1:0] i_delay_target,
    input  logic [DATA_BIT-1:0]   i_feedback_target,
    input  logic [DATA_BIT-1:0]   i_wet_target,
    input  logic [DATA_BIT-1:0]   i_dry_target,
    output logic [ADDR_WIDTH-1:0] o_delay,
    output logic [DATA_BIT-1:0]   o_feedback,
    output logic [DATA_BIT-1:0]   o_wet,
    output logic [DATA_BIT-1:0]   o_dry,
    output logic                  o_busy
);

    typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;

    localparam logic [DATA_BIT-1:0]      GAIN_MAX_V = DATA_BIT'(GAIN_MAX);
    localparam logic [DATA_BIT-1:0]      FB_MAX_V   = DATA_BIT'(FB_MAX);
    localparam logic signed [DATA_BIT:0] STEP_S     = (DATA_BIT+1)'(STEP);

    state_t                state;
    logic [ADDR_WIDTH-1:0] len_c;
    logic [DATA_BIT-1:0]   fb_c, wet_c, dry_c;
    logic [DATA_BIT-1:0]   fb_goal, wet_goal;
    logic                  len_mm;
    logic                  len_change;

    function automatic logic [DATA_BIT-1:0] clamp_gain(
        input logic [DATA_BIT-1:0] t,
        input logic [DATA_BIT-1:0] max_v
    );
        if (t[DATA_BIT-1])
            return '0;
        else if (t > max_v)
            return max_v;
        else
            return t;
    endfunction

    // One extra bit of headroom so the step never wraps before the clamp to goal.
    function automatic logic [DATA_BIT-1:0] slew(
        input logic [DATA_BIT-1:0] cur,
        input logic [DATA_BIT-1:0] goal
    );
        logic signed [DATA_BIT:0] c, g, nxt;
        c = $signed({1'b0, cur});
        g = $signed({1'b0, goal});
        if (c < g) begin
            nxt = c + STEP_S;
            if (nxt > g) nxt = g;
        end else begin
            nxt = c - STEP_S;
            if (nxt < g) nxt = g;
        end
        return nxt[DATA_BIT-1:0];
    endfunction

    always_comb begin
        len_c    = (i_delay_target == '0) ? ADDR_WIDTH'(1) : i_delay_target;
        fb_c     = clamp_gain(i_feedback_target, FB_MAX_V);
        wet_c    = clamp_gain(i_wet_target, GAIN_MAX_V);
        dry_c    = clamp_gain(i_dry_target, GAIN_MAX_V);
        len_mm   = (len_c != o_delay);
        fb_goal  = '0;
        wet_goal = '0;
        if (state == RUN || state == FADE_IN) begin
            fb_goal  = fb_c;
            wet_goal = wet_c;
        end
    end

`ifdef DELAY_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [CNT_W-1:0]      db_cnt, db_next;
    logic [ADDR_WIDTH-1:0] db_prev;

    // db_next counts this tick too, so a value held N ticks qualifies on tick N.
    always_comb begin
        db_next = CNT_W'(1);
        if (i_delay_target == db_prev)
            db_next = (db_cnt >= CNT_W'(DEBOUNCE)) ? db_cnt : db_cnt + CNT_W'(1);
    end

    assign len_change = len_mm && (db_next >= CNT_W'(DEBOUNCE));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            db_cnt  <= '0;
            db_prev <= ADDR_WIDTH'(DELAY_RST);
        end else if (i_audio_valid) begin
            db_cnt  <= db_next;
            db_prev <= i_delay_target;
        end
    end
`else
    assign len_change = len_mm;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= RUN;
            o_busy     <= 1'b0;
            o_delay    <= ADDR_WIDTH'(DELAY_RST);
            o_feedback <= '0;
            o_wet      <= '0;
            o_dry      <= '0;
        end else if (i_audio_valid) begin
            o_dry      <= slew(o_dry, dry_c);
            o_wet      <= slew(o_wet, wet_goal);
            o_feedback <= slew(o_feedback, fb_goal);
            case (state)
                RUN: begin
                    if (len_change) begin
                        state  <= FADE_OUT;
                        o_busy <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    // A target returning to the current length wins over a finished fade.
                    if (!len_mm) begin
                        state  <= FADE_IN;
                        o_busy <= 1'b1;
                    end else if (o_wet == '0 && o_feedback == '0) begin
                        state  <= SWITCH;
                        o_busy <= 1'b1;
                    end
                end
                SWITCH: begin
                    o_delay <= len_c;
                    state   <= FADE_IN;
                    o_busy  <= 1'b1;
                end
                FADE_IN: begin
                    if (len_change) begin
                        state  <= FADE_OUT;
                        o_busy <= 1'b1;
                    end else if (o_wet == wet_c && o_feedback == fb_c) begin
                        state  <= RUN;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_ctrl_smoother.sv
// Bench for delay_ctrl_smoother: constant-table vectors, directed length-change
// sequences, and randomized targets against an arithmetic reference model.
module tb_delay_ctrl_smoother;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int STEP = 64;
    localparam int GMAX = 16384;
    localparam int FMAX = 15565;
    localparam int DRST = 1000;
    localparam int DEB  = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [AW-1:0] d_in;
    logic [DW-1:0] fb_in, wet_in, dry_in;
    logic [AW-1:0] o_delay;
    logic [DW-1:0] o_feedback, o_wet, o_dry;
    logic          o_busy;

    always #5 clk = ~clk;

    delay_ctrl_smoother #(
        .ADDR_WIDTH(AW), .DATA_BIT(DW), .STEP(STEP), .GAIN_MAX(GMAX),
        .FB_MAX(FMAX), .DELAY_RST(DRST), .DEBOUNCE(DEB)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_audio_valid(valid),
        .i_delay_target(d_in), .i_feedback_target(fb_in),
        .i_wet_target(wet_in), .i_dry_target(dry_in),
        .o_delay(o_delay), .o_feedback(o_feedback), .o_wet(o_wet),
        .o_dry(o_dry), .o_busy(o_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Targets applied at the next tick
    logic [AW-1:0] t_d;
    logic [DW-1:0] t_fb, t_wet, t_dry;

    // Reference model: phase 0 steady, 1 fading out, 2 switching, 3 fading in
    int m_delay, m_fb, m_wet, m_dry, m_phase, m_prev, m_hold;

    function automatic int clampg(logic [DW-1:0] v, int mx);
        int s;
        s = int'($signed(v));
        if (s < 0) return 0;
        if (s > mx) return mx;
        return s;
    endfunction

    function automatic int approach(int cur, int goal);
        int diff;
        diff = goal - cur;
        if (diff > STEP) diff = STEP;
        if (diff < -STEP) diff = -STEP;
        return cur + diff;
    endfunction

    task automatic model_reset();
        m_delay = DRST; m_fb = 0; m_wet = 0; m_dry = 0; m_phase = 0;
        m_prev = DRST; m_hold = 0;
    endtask

    task automatic model_tick();
        int len, wg, fg, dg, nphase, ndelay;
        bit pass, want;
        len = (t_d == 0) ? 1 : int'(t_d);
        wg = clampg(t_wet, GMAX);
        fg = clampg(t_fb, FMAX);
        dg = clampg(t_dry, GMAX);
        pass = (m_phase == 0 || m_phase == 3);
        want = (len != m_delay);
`ifdef DELAY_CTRL_DEBOUNCE_EN
        m_hold = (int'(t_d) == m_prev) ? ((m_hold >= DEB) ? DEB : m_hold + 1) : 1;
        m_prev = int'(t_d);
        want = want && (m_hold >= DEB);
`endif
        nphase = m_phase;
        ndelay = m_delay;
        case (m_phase)
            0: if (want) nphase = 1;
            1: if (len == m_delay) nphase = 3;
               else if (m_wet == 0 && m_fb == 0) nphase = 2;
            2: begin ndelay = len; nphase = 3; end
            default: if (want) nphase = 1;
                     else if (m_wet == wg && m_fb == fg) nphase = 0;
        endcase
        m_dry = approach(m_dry, dg);
        m_wet = approach(m_wet, pass ? wg : 0);
        m_fb  = approach(m_fb, pass ? fg : 0);
        m_phase = nphase;
        m_delay = ndelay;
    endtask

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(string name);
        chk({name, ".delay"}, int'(o_delay), m_delay);
        chk({name, ".fb"}, int'(o_feedback), m_fb);
        chk({name, ".wet"}, int'(o_wet), m_wet);
        chk({name, ".dry"}, int'(o_dry), m_dry);
        chk({name, ".busy"}, int'(o_busy), (m_phase != 0) ? 1 : 0);
    endtask

    task automatic chk_all(string name, int ed, int ef, int ew, int edr, int eb);
        chk({name, ".delay"}, int'(o_delay), ed);
        chk({name, ".fb"}, int'(o_feedback), ef);
        chk({name, ".wet"}, int'(o_wet), ew);
        chk({name, ".dry"}, int'(o_dry), edr);
        chk({name, ".busy"}, int'(o_busy), eb);
    endtask

    // One tick cycle; outputs are sampled at the falling edge after it
    task automatic tick();
        @(negedge clk);
        d_in = t_d; fb_in = t_fb; wet_in = t_wet; dry_in = t_dry;
        valid = 1'b1;
        model_tick();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Non-tick cycle with scrambled targets; nothing may move
    task automatic glitch();
        @(negedge clk);
        valid = 1'b0;
        d_in = AW'($urandom); fb_in = DW'($urandom);
        wet_in = DW'($urandom); dry_in = DW'($urandom);
    endtask

    task automatic set_t(int d, int fb, int wet, int dry);
        t_d = AW'(d); t_fb = DW'(fb); t_wet = DW'(wet); t_dry = DW'(dry);
    endtask

    task automatic mid_reset(string name);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all(name, DRST, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int n;
        int d, fb, wet, dry;
        int e_delay, e_fb, e_wet, e_dry, e_busy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst = 1'b1; valid = 1'b0;
        set_t(DRST, 0, 0, 0);
        d_in = t_d; fb_in = t_fb; wet_in = t_wet; dry_in = t_dry;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset", DRST, 0, 0, 0, 0);
        rst = 1'b0;

        tbl[0] = '{1,   1000, 0,      0,      0,      1000, 0,     0,    0,     0};
        tbl[1] = '{255, 1000, 0,      0,      16384,  1000, 0,     0,    16320, 0};
        tbl[2] = '{1,   1000, 0,      0,      16384,  1000, 0,     0,    16384, 0};
        tbl[3] = '{5,   1000, 0,      0,      16384,  1000, 0,     0,    16384, 0};
        tbl[4] = '{300, 1000, 'h7FFF, 'hFF9C, 16384,  1000, 15565, 0,    16384, 0};
        tbl[5] = '{128, 1000, 8192,   8192,   16384,  1000, 8192,  8192, 16384, 0};
        tbl[6] = '{10,  1000, 8192,   8192,   'hFFFB, 1000, 8192,  8192, 15744, 0};
        tbl[7] = '{10,  1000, 8192,   8192,   20000,  1000, 8192,  8192, 16384, 0};
        for (int i = 0; i < 8; i++) begin
            set_t(tbl[i].d, tbl[i].fb, tbl[i].wet, tbl[i].dry);
            ticks(tbl[i].n);
            chk_all($sformatf("tbl%0d", i), tbl[i].e_delay, tbl[i].e_fb,
                    tbl[i].e_wet, tbl[i].e_dry, tbl[i].e_busy);
        end

        for (int i = 0; i < 5; i++) glitch();
        chk_all("hold_nontick", 1000, 8192, 8192, 16384, 0);

`ifndef DELAY_CTRL_DEBOUNCE_EN
        // Length change 1000 -> 4000 with wet=fb=8192
        set_t(4000, 8192, 8192, 16384);
        tick();      chk_all("sw_T0", 1000, 8192, 8192, 16384, 1);
        ticks(64);   chk_all("sw_T64", 1000, 4096, 4096, 16384, 1);
        ticks(64);   chk_all("sw_T128", 1000, 0, 0, 16384, 1);
        tick();      chk_all("sw_T129", 1000, 0, 0, 16384, 1);
        tick();      chk_all("sw_T130", 4000, 0, 0, 16384, 1);
        ticks(128);  chk_all("sw_T258", 4000, 8192, 8192, 16384, 1);
        tick();      chk_all("sw_T259", 4000, 8192, 8192, 16384, 0);

        // Retarget during fade-in
        set_t(3000, 8192, 8192, 16384);
        ticks(131);  chk_all("fi_start", 3000, 0, 0, 16384, 1);
        ticks(10);   chk_all("fi_10", 3000, 640, 640, 16384, 1);
        t_d = AW'(2000);
        tick();      chk_all("fi_retarget", 3000, 704, 704, 16384, 1);
        tick();      chk_all("fi_down", 3000, 640, 640, 16384, 1);
        ticks(10);   chk_all("fi_zero", 3000, 0, 0, 16384, 1);
        ticks(2);    chk_all("fi_switched", 2000, 0, 0, 16384, 1);
        ticks(129);  chk_all("fi_run", 2000, 8192, 8192, 16384, 0);

        // Abort: target returns to o_delay while fading out
        t_d = AW'(500);
        tick();      chk_all("ab_T0", 2000, 8192, 8192, 16384, 1);
        ticks(6);    chk_all("ab_down", 2000, 7808, 7808, 16384, 1);
        t_d = AW'(2000);
        tick();      chk_all("ab_back", 2000, 7744, 7744, 16384, 1);
        ticks(7);    chk_all("ab_up", 2000, 8192, 8192, 16384, 1);
        tick();      chk_all("ab_run", 2000, 8192, 8192, 16384, 0);
`else
        // Length target toggling faster than the debounce window never starts a fade
        begin
            int busy_seen;
            busy_seen = 0;
            for (int s = 0; s < 6; s++) begin
                t_d = AW'((s % 2 == 0) ? 3000 : 2000);
                for (int i = 0; i < 100; i++) begin
                    tick();
                    busy_seen = busy_seen | int'(o_busy);
                end
            end
            chk("db_toggle_busy", busy_seen, 0);
        end
        t_d = AW'(3000);
        ticks(255);  chk("db_hold255_busy", int'(o_busy), 0);
        tick();      chk("db_hold256_busy", int'(o_busy), 1);
        chk_model("db_model");
`endif
        chk_model("directed_end");

        // Reset in the middle of a fade, then hold reset values
        set_t(1234, 8192, 8192, 16384);
        ticks(3);
        mid_reset("mid_reset");
        set_t(DRST, 0, 0, 0);
        ticks(20);
        chk_all("post_reset_hold", DRST, 0, 0, 0, 0);

        // Randomized targets against the model
        begin
            int dl[6] = '{0, 1, 1000, 2000, 4000, 16383};
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(149) == 0)
                    t_d = AW'(dl[$urandom_range(5)]);
                if ($urandom_range(39) == 0) t_fb  = DW'($urandom);
                if ($urandom_range(39) == 0) t_wet = DW'($urandom);
                if ($urandom_range(39) == 0) t_dry = DW'($urandom);
                if ($urandom_range(3) == 0) glitch();
                tick();
                chk_model($sformatf("rnd%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
